// File: rtl/pong_pkg.sv
// Shared pong constants and types: match states, winner codes, score width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pong_pkg;

  localparam int SCORE_W = 4;

  // Match defaults, also read by the overlay renderer and the UART link logic
  localparam int DEF_WIN_SCORE    = 9;
  localparam int DEF_SERVE_FRAMES = 120;
  localparam int DEF_POINT_FRAMES = 60;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Score increment that sticks at the top code instead of wrapping
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle between the input logic / ball datapath and the match sequencer.
// Latency: none (wires only).
// Backpressure: none; all signals are pulses or levels.
interface game_flow_ctrl_if;
  import pong_pkg::*;

  logic               timing_tick;
  logic               start;
  logic               miss_left;
  logic               miss_right;
  logic               ball_run;
  logic               ball_center;
  logic               serve_dir;
  logic [SCORE_W-1:0] player1_score;
  logic [SCORE_W-1:0] player2_score;
  logic [2:0]         game_state;
  logic [1:0]         winner;

  // Controller side
  modport slave (
    input  timing_tick, start, miss_left, miss_right,
    output ball_run, ball_center, serve_dir, player1_score, player2_score,
           game_state, winner
  );

  // Environment side (input logic, ball datapath, overlay)
  modport master (
    output timing_tick, start, miss_left, miss_right,
    input  ball_run, ball_center, serve_dir, player1_score, player2_score,
           game_state, winner
  );

endinterface

// File: rtl/game_flow_ctrl.sv
// Pong match sequencer: idle, serve countdown, rally, point pause, game over; owns scores.
// Latency: outputs registered, decoded from next state, so they move with the state register.
// Backpressure: none; misses outside PLAY and start edges outside IDLE/OVER are dropped.
module game_flow_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  game_flow_ctrl_if.slave  gf
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES + 1) : 1;

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_THR    = SCORE_W'(WIN_SCORE);

  game_state_t        state_q, next_state;
  logic [CNT_W-1:0]   cnt_q;
  logic               start_q;
  logic               armed_q;
  logic               start_rise;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic               serve_q, serve_d;
  logic [1:0]         win_q, win_d;
  logic               run_q, center_q;

  // armed_q only sets once start has been seen low since reset, so a button
  // held through reset cannot kick off a match on its own.
  assign start_rise = gf.start & ~start_q & armed_q;

  // Next-state, score, serve direction and winner decisions
  always_comb begin
    next_state = state_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    serve_d    = serve_q;
    win_d      = win_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          p1_d       = '0;
          p2_d       = '0;
          win_d      = WIN_NONE;
          serve_d    = 1'b0;
          next_state = SERVE;
        end
      end
      SERVE: begin
        if (gf.timing_tick && cnt_q == SERVE_LAST) next_state = PLAY;
      end
      PLAY: begin
        if (gf.miss_left && gf.miss_right) begin
          // Ambiguous double miss: replay the point without scoring
          next_state = POINT;
        end else if (gf.miss_left) begin
          p2_d       = sat_inc(p2_q);
          serve_d    = 1'b0;
          next_state = POINT;
        end else if (gf.miss_right) begin
          p1_d       = sat_inc(p1_q);
          serve_d    = 1'b1;
          next_state = POINT;
        end
      end
      POINT: begin
        if (gf.timing_tick && cnt_q == POINT_LAST) begin
          if (p1_q >= WIN_THR) begin
            win_d      = WIN_P1;
            next_state = OVER;
          end else if (p2_q >= WIN_THR) begin
            win_d      = WIN_P2;
            next_state = OVER;
          end else begin
            next_state = SERVE;
          end
        end
      end
      OVER: begin
        if (start_rise) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, frame counter, scores and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      serve_q  <= 1'b0;
      win_q    <= WIN_NONE;
      run_q    <= 1'b0;
      center_q <= 1'b1;
    end else begin
      state_q  <= next_state;
      start_q  <= gf.start;
      armed_q  <= armed_q | ~gf.start;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      serve_q  <= serve_d;
      win_q    <= win_d;
      run_q    <= (next_state == PLAY);
      center_q <= (next_state != PLAY);
      // A tick landing on a transition belongs to the old state, not the new one
      if (next_state != state_q) cnt_q <= '0;
      else if (gf.timing_tick)   cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign gf.ball_run      = run_q;
  assign gf.ball_center   = center_q;
  assign gf.serve_dir     = serve_q;
  assign gf.player1_score = p1_q;
  assign gf.player2_score = p2_q;
  assign gf.game_state    = state_q;
  assign gf.winner        = win_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed match scenarios, per-cycle model compare, literal spot checks.
// Latency: model and DUT outputs compared one half-cycle after each clock edge.
// Backpressure: not applicable.
module tb_game_flow_ctrl;

  localparam int WIN   = 4;
  localparam int SERVE = 3;
  localparam int PNT   = 2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic chk_en;

  game_flow_ctrl_if gf();

  game_flow_ctrl #(
    .WIN_SCORE   (WIN),
    .SERVE_FRAMES(SERVE),
    .POINT_FRAMES(PNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gf (gf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: phase 0..4, frames still to wait in a timed phase
  int m_phase, m_left, m_p1, m_p2, m_sd, m_win;
  bit m_prev_start, m_seen_low;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: timed phases count frames down to zero
  always @(posedge clk) begin : model
    int ph, left, p1, p2, sd, w;
    bit go;
    ph = m_phase; left = m_left; p1 = m_p1; p2 = m_p2; sd = m_sd; w = m_win;
    if (rst) begin
      m_phase <= 0; m_left <= 0; m_p1 <= 0; m_p2 <= 0; m_sd <= 0; m_win <= 0;
      m_prev_start <= 1'b0; m_seen_low <= 1'b0;
    end else begin
      go = gf.start && !m_prev_start && m_seen_low;
      if (ph == 0) begin
        if (go) begin p1 = 0; p2 = 0; w = 0; sd = 0; ph = 1; left = SERVE; end
      end else if (ph == 1) begin
        if (gf.timing_tick) begin
          left = left - 1;
          if (left == 0) ph = 2;
        end
      end else if (ph == 2) begin
        if (gf.miss_left || gf.miss_right) begin
          if (!(gf.miss_left && gf.miss_right)) begin
            if (gf.miss_left) begin p2 = (p2 < 15) ? p2 + 1 : 15; sd = 0; end
            else              begin p1 = (p1 < 15) ? p1 + 1 : 15; sd = 1; end
          end
          ph = 3; left = PNT;
        end
      end else if (ph == 3) begin
        if (gf.timing_tick) begin
          left = left - 1;
          if (left == 0) begin
            if (p1 >= WIN)      begin w = 1; ph = 4; end
            else if (p2 >= WIN) begin w = 2; ph = 4; end
            else                begin ph = 1; left = SERVE; end
          end
        end
      end else begin
        if (go) ph = 0;
      end
      m_phase <= ph; m_left <= left; m_p1 <= p1; m_p2 <= p2; m_sd <= sd; m_win <= w;
      m_prev_start <= gf.start;
      m_seen_low   <= m_seen_low || !gf.start;
    end
  end

  // Every cycle, compare all outputs with the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("game_state",  int'(gf.game_state),    m_phase);
      check("ball_run",    int'(gf.ball_run),      (m_phase == 2) ? 1 : 0);
      check("ball_center", int'(gf.ball_center),   (m_phase == 2) ? 0 : 1);
      check("serve_dir",   int'(gf.serve_dir),     m_sd);
      check("p1_score",    int'(gf.player1_score), m_p1);
      check("p2_score",    int'(gf.player2_score), m_p2);
      check("winner",      int'(gf.winner),        m_win);
    end
  end

  task automatic cyc(input bit t, input bit s, input bit ml, input bit mr);
    @(negedge clk);
    gf.timing_tick = t;
    gf.start       = s;
    gf.miss_left   = ml;
    gf.miss_right  = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One rally ending in the given miss, then the point pause, then optionally the serve
  task automatic rally(input bit ml, input bit mr, input bit serve_after);
    cyc(1'b0, 1'b0, ml, mr);
    ticks(PNT);
    if (serve_after) ticks(SERVE);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0;
    rst = 1'b1;
    gf.timing_tick = 1'b0; gf.start = 1'b0; gf.miss_left = 1'b0; gf.miss_right = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_center", int'(gf.ball_center), 1);
    check("rst_run",    int'(gf.ball_run), 0);
    check("rst_state",  int'(gf.game_state), 0);
    check("rst_score",  int'({gf.player1_score, gf.player2_score}), 0);
    check("rst_winner", int'(gf.winner), 0);
    @(negedge clk) rst = 1'b0;

    // Idle with start low and frame ticks running
    for (int i = 0; i < 1000; i++) cyc((i % 10) == 0, 1'b0, 1'b0, 1'b0);
    check("idle_state", int'(gf.game_state), 0);

    // Serve countdown of three frames
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("serve_enter", int'(gf.game_state), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    check("serve_hold_run", int'(gf.ball_run), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("play_run",   int'(gf.ball_run), 1);
    check("play_state", int'(gf.game_state), 2);

    // Right miss scores for player1
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("pt_run",   int'(gf.ball_run), 0);
    check("pt_p1",    int'(gf.player1_score), 1);
    check("pt_dir",   int'(gf.serve_dir), 1);
    check("pt_state", int'(gf.game_state), 3);
    ticks(PNT);
    check("pt_to_serve", int'(gf.game_state), 1);

    // Misses and start edges during serve are ignored
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("serve_ign_state", int'(gf.game_state), 1);
    check("serve_ign_p2",    int'(gf.player2_score), 0);
    ticks(SERVE);

    // Double miss: pause without scoring
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("dbl_state", int'(gf.game_state), 3);
    check("dbl_p1",    int'(gf.player1_score), 1);
    check("dbl_dir",   int'(gf.serve_dir), 1);
    ticks(PNT);
    ticks(SERVE);

    // Player2 wins 4-1
    rally(1'b1, 1'b0, 1'b1);
    rally(1'b1, 1'b0, 1'b1);
    rally(1'b1, 1'b0, 1'b1);
    rally(1'b1, 1'b0, 1'b0);
    check("over_state",  int'(gf.game_state), 4);
    check("over_winner", int'(gf.winner), 2);
    check("over_p2",     int'(gf.player2_score), 4);
    ticks(3);
    check("over_hold", int'(gf.game_state), 4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("over_to_idle", int'(gf.game_state), 0);
    check("idle_keep_p2", int'(gf.player2_score), 4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("new_state",  int'(gf.game_state), 1);
    check("new_scores", int'({gf.player1_score, gf.player2_score}), 0);
    check("new_winner", int'(gf.winner), 0);
    ticks(SERVE);

    // Build 3/1, then reset mid-rally with start held high
    rally(1'b0, 1'b1, 1'b1);
    rally(1'b0, 1'b1, 1'b1);
    rally(1'b1, 1'b0, 1'b1);
    rally(1'b0, 1'b1, 1'b1);
    check("mid_p1", int'(gf.player1_score), 3);
    check("mid_p2", int'(gf.player2_score), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; gf.start = 1'b1;
    @(posedge clk); #1;
    check("mrst_state",  int'(gf.game_state), 0);
    check("mrst_score",  int'({gf.player1_score, gf.player2_score}), 0);
    check("mrst_center", int'(gf.ball_center), 1);
    check("mrst_run",    int'(gf.ball_run), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("held_start_idle", int'(gf.game_state), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("repress_serve", int'(gf.game_state), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
